// File: rtl/pkt_src_arbiter_pkg.sv
//============================================================================
// Module   : pkt_src_arbiter_pkg
// Brief    : Shared types, widths and helpers for the two-source packet arbiter
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package pkt_src_arbiter_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int CTRL_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic logic is_ctrl(input logic [CTRL_WIDTH-1:0] ctrl);
        return (ctrl != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_in_fifo.sv
//============================================================================
// Module   : pkt_in_fifo
// Brief    : Small synchronous FIFO with first-word-fall-through head
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pkt_in_fifo #(
    parameter int WIDTH = 72,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int          c_depth_i = 1 << AW;
    localparam logic [AW:0] c_depth   = (AW+1)'(c_depth_i);

    logic [WIDTH-1:0] r_mem [c_depth_i];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is still taken when the head leaves the same cycle.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_depth) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pkt_src_arbiter.sv
//============================================================================
// Module   : pkt_src_arbiter
// Brief    : Round-robin whole-packet arbiter of two buffered sources onto one port
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pkt_src_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int FIFO_AW    = 2,
    parameter int RDY_SLACK  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_wr,
    output logic                  in0_rdy,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_wr,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [7:0]            drop_cnt
);

    import pkt_src_arbiter_pkg::*;

    localparam int               c_fw    = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(1 << FIFO_AW);
    localparam logic [FIFO_AW:0] c_slack = (FIFO_AW+1)'(RDY_SLACK);

    logic [c_fw-1:0]    w_in_word [2];
    logic [1:0]         w_in_wr;
    logic [c_fw-1:0]    w_head    [2];
    logic [FIFO_AW:0]   w_count   [2];
    logic [1:0]         w_full;
    logic [1:0]         w_empty;
    logic [1:0]         w_rdy;
    logic [1:0]         w_qual;
    logic [1:0]         w_orphan_cand;
    logic [1:0]         w_ovf;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant;
    logic               w_grant_nxt;
    logic               r_rr_ptr;
    logic               w_rr_nxt;
    logic               r_seen_data;
    logic               w_seen_nxt;
    logic [1:0]         w_pop;
    logic [1:0]         w_orphan_pop;
    logic               w_fwd;
    logic [c_fw-1:0]    w_fwd_word;

    logic               r_out_wr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic [7:0]         r_drop_cnt;
    logic [2:0]         w_drop_evt;
    logic [8:0]         w_drop_sum;

    assign w_in_word[0] = {in0_ctrl, in0_data};
    assign w_in_word[1] = {in1_ctrl, in1_data};
    assign w_in_wr      = {in1_wr, in0_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            pkt_in_fifo #(
                .WIDTH (c_fw),
                .AW    (FIFO_AW)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (w_in_wr[gi]),
                .push_data (w_in_word[gi]),
                .pop       (w_pop[gi]),
                .head      (w_head[gi]),
                .full      (w_full[gi]),
                .empty     (w_empty[gi]),
                .count     (w_count[gi])
            );

            assign w_rdy[gi]         = ((c_depth - w_count[gi]) >= c_slack);
            assign w_qual[gi]        = !w_empty[gi] &&  is_ctrl(w_head[gi][c_fw-1 -: CTRL_WIDTH]);
            assign w_orphan_cand[gi] = !w_empty[gi] && !is_ctrl(w_head[gi][c_fw-1 -: CTRL_WIDTH]);
            assign w_ovf[gi]         = w_in_wr[gi] && w_full[gi] && !w_pop[gi];
        end
    endgenerate

    assign in0_rdy = w_rdy[0];
    assign in1_rdy = w_rdy[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_seen_data <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_seen_data <= w_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr_ptr;
        w_seen_nxt   = r_seen_data;
        w_pop        = '0;
        w_orphan_pop = '0;
        w_fwd        = 1'b0;
        w_fwd_word   = w_head[r_grant];
        case (r_state)
            ST_IDLE: begin
                // Headless data words can never start a packet, so flush them here.
                w_orphan_pop = w_orphan_cand;
                w_pop        = w_orphan_cand;
                if (w_qual[r_rr_ptr]) begin
                    w_grant_nxt = r_rr_ptr;
                    w_state_nxt = ST_SEND;
                    w_seen_nxt  = 1'b0;
                end else if (w_qual[~r_rr_ptr]) begin
                    w_grant_nxt = ~r_rr_ptr;
                    w_state_nxt = ST_SEND;
                    w_seen_nxt  = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_rdy && !w_empty[r_grant]) begin
                    w_fwd          = 1'b1;
                    w_pop[r_grant] = 1'b1;
                    if (!is_ctrl(w_fwd_word[c_fw-1 -: CTRL_WIDTH])) begin
                        w_seen_nxt = 1'b1;
                    end else if (r_seen_data) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = ~r_grant;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
        end else begin
            r_out_wr <= w_fwd;
            if (w_fwd) begin
                r_out_data <= w_fwd_word[DATA_WIDTH-1:0];
                r_out_ctrl <= w_fwd_word[c_fw-1 -: CTRL_WIDTH];
            end
        end
    end

    // Up to four drop events per cycle; the 9-bit sum cannot wrap before saturation.
    assign w_drop_evt = 3'(w_ovf[0]) + 3'(w_ovf[1]) + 3'(w_orphan_pop[0]) + 3'(w_orphan_pop[1]);
    assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop_evt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign out_wr   = r_out_wr;
    assign out_data = r_out_data;
    assign out_ctrl = r_out_ctrl;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire
